// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared types and defaults for the two-requester RAM port arbiter.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;

    // Arbiter FSM states
    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        RD_ISSUE,
        RD_WAIT,
        ACK
    } arb_state_e;

    // Requester identifiers, also used as the round-robin history bit
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester A/B handshakes plus the RAM strobe/address/data bus.
// slave  = arbiter side, master = client logic and RAM side.
interface ram_port_arbiter_if
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    // Requester A
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;
    // Requester B
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;
    // RAM side
    logic              WriteReady;
    logic              ReadReady;
    logic              write;
    logic              read;
    logic [ADDR_W-1:0] WriteAddr;
    logic [ADDR_W-1:0] ReadAddr;
    logic [DATA_W-1:0] WriteData;
    logic [DATA_W-1:0] ReadData;
    // Status
    logic              err;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_rdata,
        input  WriteReady, ReadReady, ReadData,
        output write, read, WriteAddr, ReadAddr, WriteData,
        output err
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_rdata,
        output WriteReady, ReadReady, ReadData,
        input  write, read, WriteAddr, ReadAddr, WriteData,
        input  err
    );

endinterface

// File: rtl/ram_port_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin picker, pure combinational logic.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_e    last_grant,
    output req_id_e    grant
);

    // Select the sole requester, or alternate against last_grant on a tie
    always_comb begin
        // NOTE: a default assignment first keeps every path assigned, so no latch is inferred.
        grant = REQ_A;
        case (req)
            2'b10:   grant = REQ_B;
            2'b11:   grant = (last_grant == REQ_A) ? REQ_B : REQ_A;
            default: grant = REQ_A;
        endcase
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: serialises single accesses from requesters A and B onto one RAM
// write/read port pair with round-robin priority.
// Optional read watchdog: define RAM_ARB_TIMEOUT_EN to build the TIMEOUT_CYC counter
// and the sticky err flag; otherwise err is tied low and reads wait indefinitely.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clock,
    input  logic               reset,
    ram_port_arbiter_if.slave  bus
);

    arb_state_e        r_state;
    req_id_e           r_gnt;
    req_id_e           r_last_grant;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [DATA_W-1:0] r_a_rdata;
    logic [DATA_W-1:0] r_b_rdata;
    logic              r_a_ack;
    logic              r_b_ack;

    logic [1:0]        w_req;
    req_id_e           w_grant;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_write;
    logic              w_read;

`ifdef RAM_ARB_TIMEOUT_EN
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0]           r_tmo_cnt;
    logic                       r_err;
`else
    // TIMEOUT_CYC only matters to the watchdog; fold it here so it stays referenced.
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CYC;
`endif

    assign w_req = {bus.b_req, bus.a_req};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .grant      (w_grant)
    );

    // Winner's request fields, latched in IDLE
    assign w_sel_we    = (w_grant == REQ_B) ? bus.b_we    : bus.a_we;
    assign w_sel_addr  = (w_grant == REQ_B) ? bus.b_addr  : bus.a_addr;
    assign w_sel_wdata = (w_grant == REQ_B) ? bus.b_wdata : bus.a_wdata;

    // Strobes follow the ready inputs within the issue cycle so the RAM sees them the
    // cycle it becomes ready; reset masks them immediately so an aborted access never
    // presents a strobe while reset is high.
    assign w_write = !reset && (r_state == WR_ISSUE) && bus.WriteReady;
    assign w_read  = !reset && (((r_state == RD_ISSUE) && bus.ReadReady) ||
                                (r_state == RD_WAIT));

    // Arbitration FSM with registered acks, addresses, write data and read data
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_gnt        <= REQ_A;
            r_last_grant <= REQ_B;
            r_wr_addr    <= '0;
            r_rd_addr    <= '0;
            r_wr_data    <= '0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_err        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_a_ack <= 1'b0;
            r_b_ack <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_gnt        <= w_grant;
                        r_last_grant <= w_grant;
                        if (w_sel_we) begin
                            r_wr_addr <= w_sel_addr;
                            r_wr_data <= w_sel_wdata;
                            r_state   <= WR_ISSUE;
                        end else begin
                            r_rd_addr <= w_sel_addr;
                            r_state   <= RD_ISSUE;
`ifdef RAM_ARB_TIMEOUT_EN
                            r_tmo_cnt <= '0;
`endif
                        end
                    end
                end
                WR_ISSUE: begin
                    if (bus.WriteReady) begin
                        r_state <= ACK;
                        r_a_ack <= (r_gnt == REQ_A);
                        r_b_ack <= (r_gnt == REQ_B);
                    end
                end
                RD_ISSUE, RD_WAIT: begin
                    if (bus.ReadReady) begin
                        if (r_state == RD_ISSUE) begin
                            r_state <= RD_WAIT;
`ifdef RAM_ARB_TIMEOUT_EN
                            r_tmo_cnt <= '0;
`endif
                        end else begin
                            if (r_gnt == REQ_A) r_a_rdata <= bus.ReadData;
                            else                r_b_rdata <= bus.ReadData;
                            r_state <= ACK;
                            r_a_ack <= (r_gnt == REQ_A);
                            r_b_ack <= (r_gnt == REQ_B);
                        end
                    end
`ifdef RAM_ARB_TIMEOUT_EN
                    else if (r_tmo_cnt == TMO_LAST) begin
                        // Watchdog expiry: give up on the RAM and complete with zero data
                        if (r_gnt == REQ_A) r_a_rdata <= '0;
                        else                r_b_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= ACK;
                        r_a_ack <= (r_gnt == REQ_A);
                        r_b_ack <= (r_gnt == REQ_B);
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                ACK:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.write     = w_write;
    assign bus.read      = w_read;
    assign bus.WriteAddr = r_wr_addr;
    assign bus.ReadAddr  = r_rd_addr;
    assign bus.WriteData = r_wr_data;
    assign bus.a_ack     = r_a_ack;
    assign bus.b_ack     = r_b_ack;
    assign bus.a_rdata   = r_a_rdata;
    assign bus.b_rdata   = r_b_rdata;
`ifdef RAM_ARB_TIMEOUT_EN
    assign bus.err       = r_err;
`else
    assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: scoreboard bench for ram_port_arbiter with a behavioural RAM.
// Define RAM_ARB_TIMEOUT_EN to also exercise the read watchdog (TIMEOUT_CYC = 8).
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW     = 4;
    localparam int DW     = 8;
    localparam int TB_TMO = 8;
    localparam logic A    = 1'b0;
    localparam logic B    = 1'b1;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_port_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TB_TMO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural RAM: write on the strobe, read data follows ReadAddr
    logic [DW-1:0] ram [16];
    always @(posedge clock) if (bus.write) ram[bus.WriteAddr] <= bus.WriteData;
    assign bus.ReadData = ram[bus.ReadAddr];

    typedef struct {
        logic          who;
        logic          is_rd;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          sb [$];
    exp_t          mon_e;
    logic [DW-1:0] exp_mem [16];
    int            n_vec = 0;
    int            n_err = 0;
    int            lat, lat_a1, lat_b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_op(input logic who, input logic we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        exp_t e;
        e.who   = who;
        e.is_rd = !we;
        e.rdata = we ? '0 : exp_mem[addr];
        if (we) exp_mem[addr] = wdata;
        sb.push_back(e);
    endtask

    task automatic drive_req(input logic who, input logic req, input logic we,
                             input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        if (who == B) begin
            bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
        end else begin
            bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
        end
    endtask

    // One access: raise req at a negedge, wait (bounded) for ack, drop req in the ack cycle.
    // lat counts cycles from the request cycle (1) to the ack cycle.
    task automatic access(input logic who, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input bit push, output int l);
        logic got;
        if (push) expect_op(who, we, addr, wdata);
        drive_req(who, 1'b1, we, addr, wdata);
        l   = 1;
        got = 1'b0;
        while (!got && l < 100) begin
            @(negedge clock);
            l++;
            got = (who == B) ? bus.b_ack : bus.a_ack;
        end
        if (!got) check("ack_wait", 0, 1);
        drive_req(who, 1'b0, we, addr, wdata);
        @(negedge clock);
    endtask

    // Monitor: strobe exclusivity and scoreboard pop on every ack
    always @(negedge clock) begin
        if (bus.write || bus.read)
            check("strobe_excl", 32'(bus.write & bus.read), 0);
        if (bus.a_ack || bus.b_ack) begin
            check("ack_onehot", 32'(bus.a_ack & bus.b_ack), 0);
            if (sb.size() == 0) begin
                check("ack_unexpected", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("ack_who", 32'(bus.b_ack), 32'(mon_e.who));
                if (mon_e.is_rd)
                    check("ack_rdata", 32'(mon_e.who ? bus.b_rdata : bus.a_rdata),
                          32'(mon_e.rdata));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        drive_req(A, 1'b0, 1'b0, '0, '0);
        drive_req(B, 1'b0, 1'b0, '0, '0);
        bus.WriteReady = 1'b1;
        bus.ReadReady  = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state
        check("rst_write",   32'(bus.write), 0);
        check("rst_read",    32'(bus.read), 0);
        check("rst_a_ack",   32'(bus.a_ack), 0);
        check("rst_b_ack",   32'(bus.b_ack), 0);
        check("rst_err",     32'(bus.err), 0);
        check("rst_waddr",   32'(bus.WriteAddr), 0);
        check("rst_wdata",   32'(bus.WriteData), 0);
        check("rst_a_rdata", 32'(bus.a_rdata), 0);
        reset = 1'b0;

        // Write then read back
        access(A, 1'b1, 4'd3, 8'h5A, 1'b1, lat);
        check("wr_lat", lat, 3);
        check("waddr_hold", 32'(bus.WriteAddr), 3);
        check("wdata_hold", 32'(bus.WriteData), 'h5A);
        access(A, 1'b0, 4'd3, 8'h00, 1'b1, lat);
        check("rd_lat", lat, 4);
        access(B, 1'b1, 4'd8, 8'h77, 1'b1, lat);
        check("a_rdata_hold", 32'(bus.a_rdata), 'h5A);

        // Contention from reset: A first, then strict alternation
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        expect_op(A, 1'b1, 4'd4, 8'h11);
        expect_op(B, 1'b1, 4'd5, 8'h22);
        expect_op(A, 1'b1, 4'd6, 8'h33);
        expect_op(B, 1'b1, 4'd7, 8'h44);
        fork
            begin
                access(A, 1'b1, 4'd4, 8'h11, 1'b0, lat_a1);
                access(A, 1'b1, 4'd6, 8'h33, 1'b0, lat_a1);
            end
            begin
                access(B, 1'b1, 4'd5, 8'h22, 1'b0, lat_b1);
                access(B, 1'b1, 4'd7, 8'h44, 1'b0, lat_b1);
            end
        join
        check("cont_sb_empty", sb.size(), 0);
        access(B, 1'b0, 4'd4, 8'h00, 1'b1, lat);
        access(A, 1'b0, 4'd7, 8'h00, 1'b1, lat);

        // Write backpressure
        bus.WriteReady = 1'b0;
        expect_op(B, 1'b1, 4'd9, 8'hC3);
        drive_req(B, 1'b1, 1'b1, 4'd9, 8'hC3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check("bp_write_low", 32'(bus.write), 0);
        end
        @(negedge clock);
        bus.WriteReady = 1'b1;
        #1;
        check("bp_write_pulse", 32'(bus.write), 1);
        check("bp_no_early_ack", 32'(bus.b_ack), 0);
        @(negedge clock);
        check("bp_ack", 32'(bus.b_ack), 1);
        check("bp_write_drop", 32'(bus.write), 0);
        drive_req(B, 1'b0, 1'b1, 4'd9, 8'hC3);
        @(negedge clock);

        // Read stall in RD_WAIT
        expect_op(B, 1'b0, 4'd9, 8'h00);
        drive_req(B, 1'b1, 1'b0, 4'd9, 8'h00);
        @(negedge clock);
        check("rs_issue_read", 32'(bus.read), 1);
        @(negedge clock);
        bus.ReadReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("rs_read_held", 32'(bus.read), 1);
            check("rs_no_ack", 32'(bus.b_ack), 0);
        end
        bus.ReadReady = 1'b1;
        @(negedge clock);
        check("rs_ack", 32'(bus.b_ack), 1);
        check("rs_rdata", 32'(bus.b_rdata), 'hC3);
        check("rs_read_drop", 32'(bus.read), 0);
        drive_req(B, 1'b0, 1'b0, 4'd9, 8'h00);
        @(negedge clock);

        // Mixed traffic: writes from alternating requesters, read back by the other one
        for (int i = 0; i < 4; i++) begin
            access(logic'(i % 2), 1'b1, AW'(10 + i), DW'($urandom_range(0, 255)), 1'b1, lat);
            check("mix_wr_lat", lat, 3);
        end
        for (int i = 0; i < 4; i++) begin
            access(logic'((i + 1) % 2), 1'b0, AW'(10 + i), 8'h00, 1'b1, lat);
            check("mix_rd_lat", lat, 4);
        end

        // Reset in RD_WAIT: access abandoned, no ack
        drive_req(A, 1'b1, 1'b0, 4'd3, 8'h00);
        @(negedge clock);
        @(negedge clock);
        bus.ReadReady = 1'b0;
        @(negedge clock);
        check("rmr_read_before", 32'(bus.read), 1);
        reset = 1'b1;
        drive_req(A, 1'b0, 1'b0, 4'd3, 8'h00);
        #1;
        check("rmr_read_same", 32'(bus.read), 0);
        @(negedge clock);
        check("rmr_read_after", 32'(bus.read), 0);
        check("rmr_no_ack", 32'(bus.a_ack), 0);
        check("rmr_err", 32'(bus.err), 0);
        reset = 1'b0;
        bus.ReadReady = 1'b1;
        @(negedge clock);
        check("rmr_no_ack_late", 32'(bus.a_ack), 0);
        access(B, 1'b1, 4'd2, 8'h99, 1'b1, lat);
        check("rmr_idle_wr_lat", lat, 3);

`ifdef RAM_ARB_TIMEOUT_EN
        // Read watchdog: RAM never ready
        bus.ReadReady = 1'b0;
        sb.push_back('{who: B, is_rd: 1'b1, rdata: '0});
        access(B, 1'b0, 4'd10, 8'h00, 1'b0, lat);
        check("tmo_lat", lat, TB_TMO + 2);
        check("tmo_err_set", 32'(bus.err), 1);
        check("tmo_rdata", 32'(bus.b_rdata), 0);
        bus.ReadReady = 1'b1;
        access(A, 1'b1, 4'd2, 8'h05, 1'b1, lat);
        check("tmo_err_sticky", 32'(bus.err), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("tmo_err_clr", 32'(bus.err), 0);
`else
        check("err_tied_low", 32'(bus.err), 0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
